// File: rtl/kernel_launch_ctrl_pkg.sv
// Shared types and helpers for the kernel launch controller.
package kernel_launch_ctrl_pkg;

  localparam int KLC_DATA_W = 8;
  localparam int KLC_TAG_W  = 4;
  localparam int KLC_CNT_W  = 16;

  // Invocation lifecycle: accept a descriptor, hold ap_start, time the run,
  // hand back one record, or park forever after a watchdog expiry.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_RUN    = 3'd2,
    ST_REPORT = 3'd3,
    ST_HALT   = 3'd4
  } klc_state_e;

  // Completion record at the default widths.
  typedef struct packed {
    logic [KLC_TAG_W-1:0] tag;
    logic [KLC_CNT_W-1:0] cycles;
    logic                 timeout;
  } klc_cpl_t;

  // Increment that sticks at the all-ones value of a w-bit counter.
  // Carried in 32 bits so callers of any width up to 32 can share it.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/kernel_launch_ctrl_if.sv
// Signal bundle between the launch controller and its environment
// (descriptor source, kernel, completion consumer).
//
// Handshake rule for both streams (desc_*, cpl_*): a transfer happens on a
// rising edge where valid and ready are both 1; the producer keeps valid and
// payload stable until that edge, and valid never depends on ready.
interface kernel_launch_ctrl_if
  import kernel_launch_ctrl_pkg::*;
#(
  parameter int DATA_W = KLC_DATA_W,
  parameter int TAG_W  = KLC_TAG_W,
  parameter int CNT_W  = KLC_CNT_W
);
  logic              desc_valid;
  logic              desc_ready;
  logic [DATA_W-1:0] desc_alpha;
  logic [DATA_W-1:0] desc_beta;
  logic [TAG_W-1:0]  desc_tag;
  logic              ap_start;
  logic              ap_ready;
  logic              ap_done;
  logic [DATA_W-1:0] alpha;
  logic [DATA_W-1:0] beta;
  logic              cpl_valid;
  logic              cpl_ready;
  logic [TAG_W-1:0]  cpl_tag;
  logic [CNT_W-1:0]  cpl_cycles;
  logic              cpl_timeout;
  logic              spurious_done;
  logic [CNT_W-1:0]  launch_count;
  klc_state_e        dbg_state;

  modport master (
    input  desc_valid, desc_alpha, desc_beta, desc_tag, ap_ready, ap_done, cpl_ready,
    output desc_ready, ap_start, alpha, beta, cpl_valid, cpl_tag, cpl_cycles,
           cpl_timeout, spurious_done, launch_count, dbg_state
  );

  modport slave (
    output desc_valid, desc_alpha, desc_beta, desc_tag, ap_ready, ap_done, cpl_ready,
    input  desc_ready, ap_start, alpha, beta, cpl_valid, cpl_tag, cpl_cycles,
           cpl_timeout, spurious_done, launch_count, dbg_state
  );
endinterface

// File: rtl/kernel_launch_ctrl_latency_counter.sv
// RUN-cycle counter: clear on launch, count while running, saturate at the
// top, and flag the cycle whose increment would reach the watchdog limit.
module kernel_launch_ctrl_latency_counter
  import kernel_launch_ctrl_pkg::*;
#(
  parameter int          CNT_W          = KLC_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_inc,
  output logic             terminal
);
  logic [CNT_W-1:0] count_q;

  assign count     = count_q;
  assign count_inc = CNT_W'(sat_inc(32'(count_q), CNT_W));
  // A zero limit disables the watchdog entirely.
  assign terminal  = (TIMEOUT_CYCLES != 0) &&
                     ((32'(count_q) + 32'd1) == 32'(TIMEOUT_CYCLES));

  // Counter register; clear wins over enable so a launch always starts at 0.
  always_ff @(posedge clk) begin
    if (!rst)        count_q <= '0;
    else if (clear)  count_q <= '0;
    else if (enable) count_q <= count_inc;
  end
endmodule

// File: rtl/kernel_launch_ctrl.sv
// Host-side invocation sequencer for a start/ready/done kernel: takes one
// descriptor at a time, drives the start handshake with stable arguments,
// times the run and returns one completion record per invocation.
module kernel_launch_ctrl
  import kernel_launch_ctrl_pkg::*;
#(
  parameter int          DATA_W         = KLC_DATA_W,
  parameter int          TAG_W          = KLC_TAG_W,
  parameter int          CNT_W          = KLC_CNT_W,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input logic                  clk,
  input logic                  rst,
  kernel_launch_ctrl_if.master bus
);
  klc_state_e        state_q, state_d;
  logic              accept, launch, finish_done, finish_to;
  logic [DATA_W-1:0] alpha_q, beta_q;
  logic [TAG_W-1:0]  tag_q;
  logic [CNT_W-1:0]  launch_cnt_q, cpl_cycles_q, count, count_inc;
  logic              ap_start_q, cpl_valid_q, cpl_timeout_q, spurious_q, terminal;

  kernel_launch_ctrl_latency_counter #(
    .CNT_W          (CNT_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_counter (
    .clk       (clk),
    .rst       (rst),
    .clear     (launch),
    .enable    (state_q == ST_RUN),
    .count     (count),
    .count_inc (count_inc),
    .terminal  (terminal)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state decode and the one-cycle strobes that steer the datapath.
  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    launch      = 1'b0;
    finish_done = 1'b0;
    finish_to   = 1'b0;
    unique case (state_q)
      ST_IDLE: if (bus.desc_valid) begin
        accept  = 1'b1;
        state_d = ST_START;
      end
      ST_START: if (bus.ap_ready) begin
        launch  = 1'b1;
        state_d = ST_RUN;
      end
      // A completion on the watchdog's last cycle still counts as a normal finish.
      ST_RUN: if (bus.ap_done) begin
        finish_done = 1'b1;
        state_d     = ST_REPORT;
      end else if (terminal) begin
        finish_to = 1'b1;
        state_d   = ST_REPORT;
      end
      // After a timeout the kernel's state is unknown, so only reset leaves HALT.
      ST_REPORT: if (bus.cpl_ready) state_d = cpl_timeout_q ? ST_HALT : ST_IDLE;
      ST_HALT:   state_d = ST_HALT;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Registered outputs, argument/tag latches and the completion record.
  always_ff @(posedge clk) begin
    if (!rst) begin
      alpha_q       <= '0;
      beta_q        <= '0;
      tag_q         <= '0;
      launch_cnt_q  <= '0;
      ap_start_q    <= 1'b0;
      cpl_valid_q   <= 1'b0;
      cpl_cycles_q  <= '0;
      cpl_timeout_q <= 1'b0;
      spurious_q    <= 1'b0;
    end else begin
      ap_start_q  <= (state_d == ST_START);
      cpl_valid_q <= (state_d == ST_REPORT);
      if (accept) begin
        alpha_q      <= bus.desc_alpha;
        beta_q       <= bus.desc_beta;
        tag_q        <= bus.desc_tag;
        launch_cnt_q <= launch_cnt_q + 1'b1;
      end
      if (finish_done) begin
        cpl_cycles_q  <= count_inc;
        cpl_timeout_q <= 1'b0;
      end else if (finish_to) begin
        cpl_cycles_q  <= CNT_W'(TIMEOUT_CYCLES);
        cpl_timeout_q <= 1'b1;
      end
      if (bus.ap_done && (state_q != ST_RUN)) spurious_q <= 1'b1;
    end
  end

  assign bus.desc_ready    = (state_q == ST_IDLE);
  assign bus.ap_start      = ap_start_q;
  assign bus.alpha         = alpha_q;
  assign bus.beta          = beta_q;
  assign bus.cpl_valid     = cpl_valid_q;
  assign bus.cpl_tag       = tag_q;
  assign bus.cpl_cycles    = cpl_cycles_q;
  assign bus.cpl_timeout   = cpl_timeout_q;
  assign bus.spurious_done = spurious_q;
  assign bus.launch_count  = launch_cnt_q;
  assign bus.dbg_state     = state_q;
endmodule

// File: doc/kernel_launch_ctrl.md
Name: kernel_launch_ctrl

Overview:
Host-side invocation sequencer placed directly upstream of a dynamatic kernel top (ap_start/ap_ready/ap_done plus scalar argument ports).
- Accepts invocation descriptors (alpha, beta, tag) on a valid/ready stream.
- Holds the arguments stable and drives ap_start through the kernel's idle→running handshake.
- Measures kernel latency and returns one completion record per invocation.
- Includes a watchdog that flags hung kernels.

Parameters:
DATA_W, 8, width of each scalar kernel argument (alpha, beta)
TAG_W, 4, width of the descriptor tag echoed in the completion
CNT_W, 16, width of the cycle counter and completion latency field
TIMEOUT_CYCLES, 4096, watchdog limit in RUN cycles; 0 disables the watchdog

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  reset, synchronous, active-low (0 = reset)
desc_valid  in  1  descriptor available
desc_ready  out  1  descriptor accepted this cycle when desc_valid&desc_ready
desc_alpha  in  DATA_W  alpha argument
desc_beta  in  DATA_W  beta argument
desc_tag  in  TAG_W  invocation tag
ap_start  out  1  kernel start request
ap_ready  in  1  kernel idle, samples ap_start and arguments this edge
ap_done  in  1  one-cycle kernel completion pulse
alpha  out  DATA_W  registered alpha to kernel
beta  out  DATA_W  registered beta to kernel
cpl_valid  out  1  completion record valid
cpl_ready  in  1  completion consumer ready
cpl_tag  out  TAG_W  tag of completed invocation
cpl_cycles  out  CNT_W  RUN-cycle latency, saturating
cpl_timeout  out  1  record produced by watchdog, not ap_done
spurious_done  out  1  sticky: ap_done seen outside RUN
launch_count  out  CNT_W  accepted descriptors since reset, wrapping

Behaviour:
- Reset (rst=0 at edge): state IDLE; counter, args, tag, launch_count cleared to 0. Resulting output values:
  - ap_start=0, cpl_valid=0, cpl_timeout=0, spurious_done=0.
  - desc_ready=1 (combinational from state).
  - Reset mid-invocation abandons it and emits no completion.
- FSM states: IDLE, START, RUN, REPORT, HALT.
- IDLE:
  - desc_ready=1.
  - On desc_valid: latch alpha/beta/tag, increment launch_count, go to START.
  - Descriptor latency to ap_start is 1 cycle.
- START:
  - ap_start=1; alpha/beta held constant.
  - On ap_ready=1 at the edge, the kernel has latched the arguments. Go to RUN and clear the counter to 0.
  - If ap_ready=0, remain in START indefinitely. The watchdog does not run in START.
- RUN:
  - ap_start=0; counter increments each cycle, saturating at 2^CNT_W-1.
  - On ap_done=1: cpl_cycles=counter+1 (saturating), cpl_timeout=0, go to REPORT.
  - Else if TIMEOUT_CYCLES≠0 and counter+1==TIMEOUT_CYCLES: cpl_cycles=TIMEOUT_CYCLES, cpl_timeout=1, go to REPORT. The watchdog then arms HALT.
  - If ap_done and the timeout condition occur in the same cycle, ap_done wins (normal completion).
- REPORT:
  - cpl_valid=1 with fields stable until cpl_ready=1 at the edge.
  - Next state is IDLE, or HALT if cpl_timeout.
  - desc_ready=0 in REPORT, so at most one invocation is in flight.
- HALT:
  - desc_ready=0, ap_start=0, no outputs change.
  - Exited only by reset, because the kernel's state is unknown after a timeout.
- ap_done=1 in any state other than RUN sets spurious_done. The pulse is otherwise ignored.
- Back-to-back: REPORT→IDLE on cpl_ready, then a new descriptor can be accepted the cycle after. Minimum gap between ap_done and the next ap_start is 3 cycles.
- All outputs are registered except desc_ready, which is a decode of the state register only.

Decomposition:
- Shared package: state enum (IDLE/START/RUN/REPORT/HALT), completion record struct {tag, cycles, timeout}, and a CNT_W saturating-increment function.
- Natural sub-module: kernel_latency_counter (clear, enable, saturate, terminal-count compare against TIMEOUT_CYCLES).

Test Plan:
- Basic launch:
  - Stimulus: desc {alpha=0x12, beta=0x34, tag=5}; ap_ready high; ap_done 10 cycles after the start edge.
  - Required: ap_start high exactly 1 cycle; alpha/beta=0x12/0x34 at the start edge; cpl {tag=5, cycles=10, timeout=0}; launch_count=1.
- Delayed ap_ready:
  - Stimulus: hold ap_ready=0 for 7 cycles.
  - Required: ap_start stays high with args stable for all 7 cycles, RUN is entered on the ap_ready edge, and cpl_cycles excludes the START cycles.
- Completion backpressure:
  - Stimulus: cpl_ready=0 for 5 cycles, with desc_valid held high for the next descriptor.
  - Required: cpl fields stable; desc_ready=0 until the handshake; the second descriptor is accepted the cycle after returning to IDLE.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16; no ap_done.
  - Required: cpl {cycles=16, timeout=1}; then HALT with desc_ready=0 until rst=0; a post-reset launch works.
- Tie and spurious done:
  - Stimulus (tie): ap_done on RUN cycle 16 with TIMEOUT_CYCLES=16.
    - Required: timeout=0, cycles=16.
  - Stimulus (spurious): ap_done pulsed in IDLE.
    - Required: spurious_done=1 and sticky; FSM unaffected.
- Reset mid-RUN:
  - Stimulus: assert rst=0 at RUN cycle 4.
  - Required: next cycle IDLE, cpl_valid=0, launch_count=0, spurious_done=0.
